adc_rec: RTL
============

// Module: adc_rec
// PURPOSE
//  I2S receive path from codec ADC into external SRAM; capture-side counterpart of the DAC playback path.
//  Deserialises adcdat on bclk, framed by adclrc, and assembles 16-bit samples.
//  Optionally decimates the samples, then writes each kept sample to SRAM at an incrementing address.
//  Shares the SRAM address/data bus with playback: outputs are high-Z while not recording.
// PARAMETERS
//  ADDR_W    18                 SRAM word-address width
//  SAMPLE_W  16                 bits per channel sample
//  ADDR_MAX  (1<<ADDR_W)-1      last writable address
// PORTS
//  bclk    in   1         codec bit clock; the only clock (all logic on posedge)
//  reset   in   1         synchronous, active-high reset
//  record  in   1         1 = capture enabled; 0 = pause, release bus
//  clr     in   1         sync pulse: addr <= 0, full <= 0 (ignored while record=1)
//  skip    in   4         keep 1 of every skip+1 samples (0 = keep all)
//  adclrc  in   1         codec LR clock: 0 = left, 1 = right
//  adcdat  in   1         codec serial data, MSB first
//  addr    out  ADDR_W    SRAM address; 'z when record=0
//  data    out  SAMPLE_W  SRAM write data; 'z when record=0
//  write   out  1         SRAM write strobe, 1 bclk wide
//  full    out  1         1 = ADDR_MAX written; capture stopped
// BEHAVIOUR
//  - Reset: state=IDLE, addr_q=0, write=0, full=0, skip_cnt=0, shift reg=0.
//  - Framing is I2S: lrc_d registers adclrc each edge; a left start is detected when lrc_d=1 and adclrc=0.
//    The start edge samples the delay slot, which is discarded. The next 16 edges shift in bits 15..0, MSB first.
//  - FSM states:
//    - IDLE -> WAIT when record=1 and full=0.
//    - WAIT -> SHIFT on a left start.
//    - SHIFT -> WRITE after the 16th bit.
//    - WRITE -> WAIT, or -> FULL if addr_q was ADDR_MAX.
//    - FULL -> IDLE when record=0.
//  - WRITE, kept sample (skip_cnt==skip): write=1 for exactly one cycle.
//    data holds the sample and addr holds addr_q during that cycle. addr_q increments on the next edge.
//    skip_cnt is then set to 0.
//  - WRITE, dropped sample (skip_cnt!=skip): write stays 0, addr_q is unchanged, skip_cnt increments.
//  - Latency: write is asserted on the edge after the LSB is sampled.
//  - Wrap-around: addr_q never wraps. Writing ADDR_MAX sets full=1. No further writes until clr.
//  - record drops mid-SHIFT or WRITE: go to IDLE on the next edge with write=0. The partial sample is lost.
//    addr_q and skip_cnt are retained, so the next record resumes at the same address.
//  - record=1 with full=1: stays in IDLE/FULL, write=0.
//  - clr with record=1 has no effect. clr together with reset: reset wins.
//  - A left start arriving during WRITE is missed; capture resyncs on the next frame. bclk >= 34 per frame.
// CONFIGURATION
//  ADC_REC_STEREO_EN defined:
//    - A right start (lrc_d=0, adclrc=1, plus delay slot) is captured the same way.
//    - Left is written to addr_q, right to addr_q+1, and addr_q advances by 2 per kept frame.
//    - The skip decision is made once per frame, so the pair is kept or dropped together.
//    - full is set when the right write lands on ADDR_MAX. A left write at ADDR_MAX also sets full.
//  Undefined: right-channel bits are ignored; mono only, addr_q advances by 1.
// STRUCTURE
//  Package adc_rec_pkg:
//    - state enum {IDLE, WAIT, SHIFT, WRITE, FULL};
//    - SAMPLE_W; bit-counter width localparam (5 bits).
//  Sub-module i2s_rx_shift: lrc edge detect, delay-slot skip and 16-bit shifter.
//    Outputs sample[15:0], sample_vld (1 cycle), chan.
//  adc_rec: FSM, decimation counter, address counter, tristate drivers.
// TESTING
//  1. Reset, record=1, skip=0, left word 16'hA5C3:
//     write pulses once with data=A5C3, addr=0; then addr=1.
//  2. skip=2, 6 frames L=1..6: writes data 1 and 4 only, at addr 0 and 1.
//  3. record dropped after 8 bits of L=16'hFFFF: no write; addr unchanged.
//     Re-record with L=16'h0001: written at the same addr.
//  4. Preload addr=ADDR_MAX-1, 3 frames: 2 writes, full=1 after the 2nd, 3rd frame ignored.
//     clr with record=0 clears full and sets addr=0.
//  5. record=0: addr and data are 'z, write=0.
//  6. STEREO_EN, L=16'h1234, R=16'h5678: writes 1234@0, then 5678@1; addr=2.

Source files
------------

// File: rtl/adc_rec_pkg.sv
// Shared types and constants for the I2S ADC capture path (adc_rec).
package adc_rec_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 5;
  localparam int SKIP_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SHIFT,
    WRITE,
    FULL
  } state_e;

endpackage

// File: rtl/adc_rec_shift.sv
// I2S receive shifter: LR-clock edge detect, delay-slot skip and MSB-first
// deserialiser; flags each completed word for one cycle with its channel.
module i2s_rx_shift
  import adc_rec_pkg::*;
(
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                lrc_i,
  input  logic                dat_i,
  output logic                lstart_o,
  output logic                rstart_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_vld_o,
  output logic                chan_o
);

  localparam logic [CNT_W-1:0] BITS    = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic                lrc_q;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                vld_q, vld_d;
  logic                chan_q, chan_d;
  logic                start;

  assign lstart_o = lrc_q & ~lrc_i;
  assign rstart_o = ~lrc_q & lrc_i;
  assign start    = lstart_o | rstart_o;

  // The start edge itself samples the delay slot, so shifting begins one edge later.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    chan_d    = chan_q;
    vld_d     = 1'b0;
    if (start) begin
      bit_cnt_d = BITS;
      chan_d    = lrc_i;
    end else if (bit_cnt_q != '0) begin
      shift_d   = {shift_q[SAMPLE_W-2:0], dat_i};
      bit_cnt_d = bit_cnt_q - CNT_ONE;
      vld_d     = (bit_cnt_q == CNT_ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      lrc_q     <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      chan_q    <= 1'b0;
    end else begin
      lrc_q     <= lrc_i;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      vld_q     <= vld_d;
      chan_q    <= chan_d;
    end
  end

  assign sample_o     = shift_q;
  assign sample_vld_o = vld_q;
  assign chan_o       = chan_q;

endmodule

// File: rtl/adc_rec.sv
// I2S ADC capture into SRAM with decimation; bus released while not recording.
// Define ADC_REC_STEREO_EN to also capture the right channel (L/R pairs).
module adc_rec
  import adc_rec_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic                bclk,
  input  logic                reset,
  input  logic                record,
  input  logic                clr,
  input  logic [SKIP_W-1:0]   skip,
  input  logic                adclrc,
  input  logic                adcdat,
  output tri   [ADDR_W-1:0]   addr,
  output tri   [SAMPLE_W-1:0] data,
  output logic                write,
  output logic                full
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [SKIP_W-1:0] SKIP_ONE = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_mux;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] data_q, data_d;

  logic                lstart, rstart, sample_vld, chan;
  logic [SAMPLE_W-1:0] sample;
  logic                keep, last_word, right_word, start_ok, frame_done;
  logic [ADDR_W-1:0]   addr_step;

  i2s_rx_shift u_shift (
    .clk_i        (bclk),
    .srst_i       (reset),
    .lrc_i        (adclrc),
    .dat_i        (adcdat),
    .lstart_o     (lstart),
    .rstart_o     (rstart),
    .sample_o     (sample),
    .sample_vld_o (sample_vld),
    .chan_o       (chan)
  );

`ifdef ADC_REC_STEREO_EN
  logic keep_q, keep_d;
  logic pend_r_q, pend_r_d;

  // The keep decision is taken on the left word and reused for its right partner.
  assign right_word = chan;
  assign keep       = right_word ? keep_q : (skip_cnt_q >= skip);
  assign last_word  = right_word ? ((addr_q + ADDR_ONE) == ADDR_MAX) : (addr_q == ADDR_MAX);
  assign start_ok   = lstart | (rstart & pend_r_q);
  assign frame_done = right_word;
  assign addr_step  = ADDR_ONE + ADDR_ONE;

  always_comb begin
    keep_d   = keep_q;
    pend_r_d = pend_r_q;
    if (state_q == IDLE) begin
      pend_r_d = 1'b0;
    end else if (state_q == WRITE && record) begin
      if (right_word) begin
        pend_r_d = 1'b0;
      end else begin
        pend_r_d = 1'b1;
        keep_d   = keep;
      end
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      keep_q   <= 1'b0;
      pend_r_q <= 1'b0;
    end else begin
      keep_q   <= keep_d;
      pend_r_q <= pend_r_d;
    end
  end
`else
  logic unused_mono;

  assign right_word  = 1'b0;
  assign keep        = (skip_cnt_q >= skip);
  assign last_word   = (addr_q == ADDR_MAX);
  assign start_ok    = lstart;
  assign frame_done  = 1'b1;
  assign addr_step   = ADDR_ONE;
  assign unused_mono = rstart ^ chan;
`endif

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (record && !full_q) state_d = WAIT;
      WAIT: begin
        if (!record)       state_d = IDLE;
        else if (start_ok) state_d = SHIFT;
      end
      SHIFT: begin
        if (!record)         state_d = IDLE;
        else if (sample_vld) state_d = WRITE;
      end
      WRITE: begin
        if (!record)                state_d = IDLE;
        else if (write && last_word) state_d = FULL;
        else                        state_d = WAIT;
      end
      FULL:    if (!record) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write    = 1'b0;
    addr_mux = addr_q;
    if (state_q == WRITE) begin
      write = record & keep;
      if (right_word) addr_mux = addr_q + ADDR_ONE;
    end
  end

  // skip_cnt >= skip rather than == lets decimation recover at once if skip is lowered.
  always_comb begin
    addr_d     = addr_q;
    skip_cnt_d = skip_cnt_q;
    full_d     = full_q;
    data_d     = data_q;
    if (state_q == SHIFT && sample_vld) data_d = sample;
    if (state_q == WRITE && record) begin
      if (!right_word) skip_cnt_d = keep ? '0 : skip_cnt_q + SKIP_ONE;
      if (keep) begin
        if (last_word)       full_d = 1'b1;
        else if (frame_done) addr_d = addr_q + addr_step;
      end
    end
    if (clr && !record) begin
      addr_d = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      addr_q     <= '0;
      skip_cnt_q <= '0;
      full_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      skip_cnt_q <= skip_cnt_d;
      full_q     <= full_d;
      data_q     <= data_d;
    end
  end

  assign addr = record ? addr_mux : {ADDR_W{1'bz}};
  assign data = record ? data_q : {SAMPLE_W{1'bz}};
  assign full = full_q;

endmodule
